flap_rate_monitor: RTL and testbench
====================================

// Module: flap_rate_monitor
// PURPOSE
//  Counts transitions of an asynchronous input over successive 1 s windows and raises a flap alarm.
//  Window boundaries come from the timer block's trigger. This block drives that timer's clear/enable.
//  Sits directly downstream of the timer. Output feeds the flap indicator display/LED logic.
// PARAMETERS
//  CNT_WIDTH     16  width of window transition counter and window_count output
//  SYNC_STAGES   2   flip-flops in the sig_in synchronizer (>=2)
//  ALARM_ON      10  alarm sets when a closed window count >= ALARM_ON
//  ALARM_OFF     4   a window "is quiet" when its count <= ALARM_OFF (ALARM_OFF < ALARM_ON)
//  HOLD_WINDOWS  3   consecutive quiet windows required to clear the alarm (>=1)
// PORTS
//  clk           in   1          system clock (100 MHz)
//  async_nreset  in   1          asynchronous, active-low reset
//  start         in   1          1-cycle request: begin monitoring
//  stop          in   1          1-cycle request: end monitoring
//  sig_in        in   1          asynchronous monitored signal
//  tick          in   1          timer trigger; one-cycle window-end pulse
//  timer_clear   out  1          to timer clear
//  timer_enable  out  1          to timer enable
//  window_count  out  CNT_WIDTH  transition count of the last closed window
//  count_valid   out  1          1-cycle pulse when window_count updates
//  flap_alarm    out  1          alarm level
//  busy          out  1          high in ARM or RUN
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 except timer_clear=1. Running count=0, quiet counter=0, sync chain=0.
//  sig_in -> SYNC_STAGES sync -> prev reg. edge = sync_out ^ prev. Both edges count.
//  FSM is registered. Outputs are decoded from state, except the registered result outputs.
//   IDLE: timer_clear=1, timer_enable=0. start -> ARM.
//   ARM (exactly 1 cycle): timer_clear=1, running count=0, prev<=sync_out (no spurious edge) -> RUN.
//   RUN: timer_clear=0, timer_enable=1.
//    - Each edge increments running count. Saturate at 2^CNT_WIDTH-1; no wrap.
//    - tick at cycle N: closing value = running count + edge(N), saturated.
//      An edge coincident with tick belongs to the closing window.
//      At N+1: window_count=closing value, count_valid=1, running count=0.
//    - Alarm update at N+1 uses the closing value:
//      >= ALARM_ON: flap_alarm=1, quiet=0.
//      <= ALARM_OFF while alarm: quiet+1; quiet reaches HOLD_WINDOWS -> flap_alarm=0, quiet=0.
//      Otherwise (between thresholds): quiet=0, alarm unchanged.
//    - stop -> IDLE next cycle. Partial window discarded: no count_valid.
//      flap_alarm=0, quiet=0. window_count holds its last value.
//  stop and tick in the same cycle: stop wins; no count_valid.
//  start and stop in the same cycle: stop wins (IDLE stays IDLE; RUN -> IDLE).
//  start in ARM/RUN is ignored. tick in IDLE/ARM is ignored.
//  Reset mid-window returns everything to the reset values. No count_valid.
//  Latency: edge on sig_in reaches the running count SYNC_STAGES+1 cycles later.
//  Latency: tick to count_valid is 1 cycle.
// STRUCTURE
//  Shared header flap_defs.vh holds:
//   - FSM state encodings IDLE=2'd0, ARM=2'd1, RUN=2'd2
//   - default thresholds and CNT_WIDTH, also used by the display logic
//  Sub-module edge_sync(SYNC_STAGES): synchronizer + prev reg + edge output + load_prev input (used by ARM).
//  Top holds the FSM, window counter, result registers and alarm/quiet logic.
//  Top-level instantiates this block with the timer: trigger->tick, timer_clear/timer_enable->clear/enable.
// TESTING (tick driven directly by the bench; sig_in toggled asynchronously to clk)
//  1 Reset, then start.
//    -> ARM for 1 cycle with timer_clear=1, then RUN with timer_enable=1, busy=1.
//  2 7 toggles, then tick.
//    -> count_valid 1 cycle after tick, window_count=7, flap_alarm=0.
//  3 Window of 12 toggles -> flap_alarm=1.
//    Then windows of 3, 6 (resets quiet), 2, 0, 4 -> alarm clears only at the count_valid of the 4.
//  4 Synced edge in the same cycle as tick -> counts in the closing window (5 toggles report 5).
//    Next window starts at 0.
//  5 CNT_WIDTH=4 build, 20 toggles in one window -> window_count=15 (saturated).
//  6 stop in the same cycle as tick after 9 toggles -> no count_valid, IDLE, flap_alarm=0, window_count unchanged.
//    Assert async_nreset mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/flap_rate_monitor_pkg.sv
// Shared definitions for the flap rate monitor: FSM states and default
// thresholds/widths, also consumed by the flap indicator display logic.
package flap_rate_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned DEF_CNT_WIDTH    = 16;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_ALARM_ON     = 10;
    localparam int unsigned DEF_ALARM_OFF    = 4;
    localparam int unsigned DEF_HOLD_WINDOWS = 3;

    // Width needed to hold values 0..max_val (never less than 1 bit).
    function automatic int unsigned width_for(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/flap_rate_monitor_edge_sync.sv
// Synchronizer for the asynchronous monitored signal plus a previous-value
// register; toggle is high for one cycle per synchronized transition.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic sig_in,
    input  logic load_prev,
    input  logic track,
    output logic toggle
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign toggle   = sync_out ^ prev_q;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Previous value follows the synchronizer while armed or running, so no
    // stale difference is seen on the first monitored cycle.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            prev_q <= 1'b0;
        end else if (load_prev || track) begin
            prev_q <= sync_out;
        end
    end

endmodule

// File: rtl/flap_rate_monitor.sv
// Flap rate monitor: counts transitions of sig_in per timer window, reports
// each closed window count and drives a hysteretic flap alarm.
module flap_rate_monitor
    import flap_rate_monitor_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned ALARM_ON     = DEF_ALARM_ON,
    parameter int unsigned ALARM_OFF    = DEF_ALARM_OFF,
    parameter int unsigned HOLD_WINDOWS = DEF_HOLD_WINDOWS
) (
    input  logic                 clk,
    input  logic                 async_nreset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 sig_in,
    input  logic                 tick,
    output logic                 timer_clear,
    output logic                 timer_enable,
    output logic [CNT_WIDTH-1:0] window_count,
    output logic                 count_valid,
    output logic                 flap_alarm,
    output logic                 busy
);

    localparam int unsigned QW = width_for(HOLD_WINDOWS);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] ON_TH     = CNT_WIDTH'(ALARM_ON);
    localparam logic [CNT_WIDTH-1:0] OFF_TH    = CNT_WIDTH'(ALARM_OFF);
    localparam logic [QW-1:0]        HOLD_LAST = QW'(HOLD_WINDOWS - 1);

    state_t               state;
    logic                 toggle;
    logic [CNT_WIDTH-1:0] run_cnt;
    logic [CNT_WIDTH-1:0] closing;
    logic [QW-1:0]        quiet;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk          (clk),
        .async_nreset (async_nreset),
        .sig_in       (sig_in),
        .load_prev    (state == ARM),
        .track        (state == RUN),
        .toggle       (toggle)
    );

    // Running count including this cycle's edge, saturated; used both as the
    // next running count and as the closing value on tick.
    always_comb begin
        closing = run_cnt;
        if (toggle && (run_cnt != CNT_MAX)) begin
            closing = run_cnt + CNT_WIDTH'(1);
        end
    end

    // Control FSM; timer and busy outputs are registered with the state so
    // they always match the state being entered. stop also aborts ARM.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state        <= IDLE;
            timer_clear  <= 1'b1;
            timer_enable <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state        <= ARM;
                        timer_clear  <= 1'b1;
                        timer_enable <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ARM: begin
                    if (stop) begin
                        state        <= IDLE;
                        timer_clear  <= 1'b1;
                        timer_enable <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        state        <= RUN;
                        timer_clear  <= 1'b0;
                        timer_enable <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state        <= IDLE;
                        timer_clear  <= 1'b1;
                        timer_enable <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    timer_clear  <= 1'b1;
                    timer_enable <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // Window counter, result registers and alarm hysteresis.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            run_cnt      <= '0;
            window_count <= '0;
            count_valid  <= 1'b0;
            flap_alarm   <= 1'b0;
            quiet        <= '0;
        end else begin
            count_valid <= 1'b0;
            if (state == ARM) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                if (stop) begin
                    run_cnt    <= '0;
                    flap_alarm <= 1'b0;
                    quiet      <= '0;
                end else if (tick) begin
                    window_count <= closing;
                    count_valid  <= 1'b1;
                    run_cnt      <= '0;
                    if (closing >= ON_TH) begin
                        flap_alarm <= 1'b1;
                        quiet      <= '0;
                    end else if (flap_alarm && (closing <= OFF_TH)) begin
                        if (quiet == HOLD_LAST) begin
                            flap_alarm <= 1'b0;
                            quiet      <= '0;
                        end else begin
                            quiet <= quiet + QW'(1);
                        end
                    end else begin
                        quiet <= '0;
                    end
                end else begin
                    run_cnt <= closing;
                end
            end
        end
    end

endmodule

// File: tb/tb_flap_rate_monitor.sv
// Self-checking bench for flap_rate_monitor: random toggle trains per window,
// checked against a plain-arithmetic window/hysteresis model.
module tb_flap_rate_monitor;

    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        async_nreset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        sig_in = 1'b0;
    logic        tick = 1'b0;

    logic        timer_clear, timer_enable, count_valid, flap_alarm, busy;
    logic [15:0] window_count;
    logic        timer_clear4, timer_enable4, count_valid4, flap_alarm4, busy4;
    logic [3:0]  window_count4;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int exp_alarm = 0;
    int exp_quiet = 0;
    int exp_wc    = 0;
    int exp_wc4   = 0;

    always #5 clk = ~clk;

    flap_rate_monitor #(
        .CNT_WIDTH(16), .SYNC_STAGES(SYNC), .ALARM_ON(10), .ALARM_OFF(4), .HOLD_WINDOWS(3)
    ) dut (
        .clk(clk), .async_nreset(async_nreset), .start(start), .stop(stop),
        .sig_in(sig_in), .tick(tick), .timer_clear(timer_clear),
        .timer_enable(timer_enable), .window_count(window_count),
        .count_valid(count_valid), .flap_alarm(flap_alarm), .busy(busy)
    );

    flap_rate_monitor #(
        .CNT_WIDTH(4), .SYNC_STAGES(SYNC), .ALARM_ON(10), .ALARM_OFF(4), .HOLD_WINDOWS(3)
    ) dut4 (
        .clk(clk), .async_nreset(async_nreset), .start(start), .stop(stop),
        .sig_in(sig_in), .tick(tick), .timer_clear(timer_clear4),
        .timer_enable(timer_enable4), .window_count(window_count4),
        .count_valid(count_valid4), .flap_alarm(flap_alarm4), .busy(busy4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Toggle sig_in n times off the clock grid, then let the last edge settle.
    task automatic toggle_n(input int n);
        for (int i = 0; i < n; i++) begin
            #2 sig_in = ~sig_in;
            repeat ($urandom_range(2, 4)) step();
        end
        repeat (SYNC + 2) step();
    endtask

    // Model: window result and alarm hysteresis from the window's toggle count.
    task automatic model_window(input int n);
        exp_wc  = n;
        exp_wc4 = (n > 15) ? 15 : n;
        if (n >= 10) begin
            exp_alarm = 1;
            exp_quiet = 0;
        end else if (exp_alarm == 1 && n <= 4) begin
            exp_quiet++;
            if (exp_quiet == 3) begin
                exp_alarm = 0;
                exp_quiet = 0;
            end
        end else begin
            exp_quiet = 0;
        end
    endtask

    // Close a window holding n toggles and compare the reported result.
    task automatic close_window(input string tag, input int n);
        model_window(n);
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++;
        if (count_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s count_valid: got %b expected 1", tag, count_valid);
        end
        checks++;
        if (window_count !== 16'(exp_wc)) begin
            errors++;
            $display("FAIL %s window_count: got %0d expected %0d", tag, window_count, exp_wc);
        end
        checks++;
        if (window_count4 !== 4'(exp_wc4)) begin
            errors++;
            $display("FAIL %s window_count(w4): got %0d expected %0d", tag, window_count4, exp_wc4);
        end
        checks++;
        if (flap_alarm !== 1'(exp_alarm)) begin
            errors++;
            $display("FAIL %s flap_alarm: got %b expected %0d", tag, flap_alarm, exp_alarm);
        end
        step();
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s count_valid pulse width: got %b expected 0", tag, count_valid);
        end
    endtask

    task automatic test_reset();
        async_nreset = 1'b0;
        sig_in = 1'($urandom_range(0, 1));
        step();
        checks++;
        if ({timer_clear, timer_enable, busy, count_valid, flap_alarm} !== 5'b10000 ||
            window_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: got clr=%b en=%b busy=%b cv=%b alarm=%b wc=%0d expected clr=1 others 0",
                     timer_clear, timer_enable, busy, count_valid, flap_alarm, window_count);
        end
        async_nreset = 1'b1;
        step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || timer_clear !== 1'b1) begin
            errors++;
            $display("FAIL start_stop_idle: got busy=%b clr=%b expected busy=0 clr=1", busy, timer_clear);
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || timer_clear !== 1'b1 || timer_enable !== 1'b0) begin
            errors++;
            $display("FAIL arm_state: got busy=%b clr=%b en=%b expected 1 1 0", busy, timer_clear, timer_enable);
        end
        step();
        checks++;
        if (busy !== 1'b1 || timer_clear !== 1'b0 || timer_enable !== 1'b1) begin
            errors++;
            $display("FAIL run_state: got busy=%b clr=%b en=%b expected 1 0 1", busy, timer_clear, timer_enable);
        end
    endtask

    task automatic test_basic();
        toggle_n(7);
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic no_early_valid: got %b expected 0", count_valid);
        end
        close_window("basic7", 7);
    endtask

    task automatic test_hysteresis();
        int seq[6] = '{12, 3, 6, 2, 0, 4};
        foreach (seq[i]) begin
            toggle_n(seq[i]);
            close_window($sformatf("hyst%0d", i), seq[i]);
        end
    endtask

    task automatic test_coincident();
        toggle_n(4);
        #2 sig_in = ~sig_in;
        step();
        step();
        // The fifth edge is at the synchronizer output during this cycle.
        close_window("coincident", 5);
        repeat (3) step();
        close_window("after_coincident", 0);
    endtask

    task automatic test_random();
        for (int w = 0; w < 8; w++) begin
            int n;
            n = $urandom_range(0, 14);
            toggle_n(n);
            close_window($sformatf("rand%0d", w), n);
        end
    endtask

    task automatic test_saturation();
        toggle_n(20);
        close_window("saturate", 20);
    endtask

    task automatic test_stop_tick();
        toggle_n(9);
        stop = 1'b1;
        tick = 1'b1;
        step();
        stop = 1'b0;
        tick = 1'b0;
        exp_alarm = 0;
        exp_quiet = 0;
        checks++;
        if (count_valid !== 1'b0 || busy !== 1'b0 || timer_clear !== 1'b1 || timer_enable !== 1'b0) begin
            errors++;
            $display("FAIL stop_tick ctrl: got cv=%b busy=%b clr=%b en=%b expected 0 0 1 0",
                     count_valid, busy, timer_clear, timer_enable);
        end
        checks++;
        if (flap_alarm !== 1'b0 || window_count !== 16'(exp_wc)) begin
            errors++;
            $display("FAIL stop_tick result: got alarm=%b wc=%0d expected alarm=0 wc=%0d",
                     flap_alarm, window_count, exp_wc);
        end
        step();
        checks++;
        if (count_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_tick late_valid: got %b expected 0", count_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        test_start();
        toggle_n(11);
        close_window("pre_reset", 11);
        toggle_n(3);
        #2 async_nreset = 1'b0;
        #1;
        checks++;
        if ({timer_clear, timer_enable, busy, count_valid, flap_alarm} !== 5'b10000 ||
            window_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got clr=%b en=%b busy=%b cv=%b alarm=%b wc=%0d expected clr=1 others 0",
                     timer_clear, timer_enable, busy, count_valid, flap_alarm, window_count);
        end
        step();
        async_nreset = 1'b1;
        exp_alarm = 0;
        exp_quiet = 0;
        step();
        checks++;
        if (count_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got cv=%b busy=%b expected 0 0", count_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_basic();
        test_hysteresis();
        test_coincident();
        test_random();
        test_saturation();
        test_stop_tick();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
